// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register-bank peripheral: write and read-back of NUM_REGS config registers.
// Optional read path is built only when SPI_READ_EN is defined.

module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module spi_regfile_periph #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int SH_W    = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam logic [2:0] SYNC_RST = 3'b001;  // ncs idles high

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [2:0] raw, syn;
  logic       ncs_s, sclk_s, copi_s;
  assign raw = {copi, sclk, ncs};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (raw[g]),
      .q    (syn[g])
    );
  end

  assign ncs_s  = syn[0];
  assign sclk_s = syn[1];
  assign copi_s = syn[2];

  logic                   sclk_d, ncs_d, armed;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   rise, fall, ncs_fall, ncs_rise;

  // Synchroniser outputs only carry pin data once vld_pipe has filled; a frame may
  // start only after a genuine high level on ncs, so a low ncs at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_d   <= 1'b0;
      ncs_d    <= 1'b1;
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      ncs_d    <= ncs_s;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      armed    <= armed | (vld_pipe[SYNC_STAGES] & ncs_s);
    end
  end

  assign rise     =  sclk_s & ~sclk_d;
  assign fall     = ~sclk_s &  sclk_d;
  assign ncs_fall = ~ncs_s  &  ncs_d;
  assign ncs_rise =  ncs_s  & ~ncs_d;

  state_t                           state;
  logic [CNT_W-1:0]                 bit_cnt;
  logic [SH_W-1:0]                  shreg;
  logic                             rw_q;
  logic [ADDR_W-1:0]                addr_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;

  logic [ADDR_W:0]   cmd_word;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok, last_bit, last_wr;

  assign cmd_word = {shreg[ADDR_W-1:0], copi_s};
  assign cmd_rw   = cmd_word[ADDR_W];
  assign cmd_addr = cmd_word[ADDR_W-1:0];
  assign wdata    = {shreg[DATA_W-2:0], copi_s};
  assign addr_ok  = {1'b0, addr_q} < (ADDR_W+1)'(NUM_REGS);
  assign last_bit = (state == DATA) && rise && !ncs_rise && (bit_cnt == CNT_W'(FRAME_W - 1));
  assign last_wr  = last_bit && rw_q && addr_ok;

`ifdef SPI_READ_EN
  logic [DATA_W-1:0] tx_sh, rd_val;
  logic              oe_q;

  // Unimplemented addresses fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_addr == ADDR_W'(i)) rd_val = regs_q[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
`ifdef SPI_READ_EN
      tx_sh     <= '0;
      oe_q      <= 1'b0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (armed && ncs_fall) begin
          state   <= CMD;
          bit_cnt <= '0;
        end
        CMD, DATA: begin
          if (ncs_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
`ifdef SPI_READ_EN
            oe_q      <= 1'b0;
`endif
          end else if (rise) begin
            shreg   <= {shreg[SH_W-2:0], copi_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (state == CMD && bit_cnt == CNT_W'(ADDR_W)) begin
              state  <= DATA;
              rw_q   <= cmd_rw;
              addr_q <= cmd_addr;
`ifdef SPI_READ_EN
              oe_q   <= ~cmd_rw;
              tx_sh  <= rd_val;
`endif
            end
            if (last_bit) begin
              state <= DONE;
`ifdef SPI_READ_EN
              oe_q  <= 1'b0;
`endif
              if (last_wr) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr_q;
              end
            end
          end
`ifdef SPI_READ_EN
          // The fall right after the last address bit keeps the MSB on cipo for the first data rise.
          else if (fall && state == DATA && bit_cnt > CNT_W'(ADDR_W + 1))
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
`endif
        end
        DONE: if (ncs_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '0;
    else
      for (int i = 0; i < NUM_REGS; i++)
        if (last_wr && addr_q == ADDR_W'(i)) regs_q[i] <= wdata;
  end

  assign regs_out = regs_q;

`ifdef SPI_READ_EN
  assign cipo    = oe_q & tx_sh[DATA_W-1];
  assign cipo_oe = oe_q;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
  logic unused_fall;
  assign unused_fall = fall;
`endif
endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: writes, read-back, bad address, abort,
// over-long frame and mid-frame reset, all with hand-computed expectations.

module tb_spi_regfile_periph;
  localparam int HALF = 80;  // sclk half period = 8 clk cycles

  logic        clk = 1'b0;
  logic        rst_n, sclk, ncs, copi;
  logic        cipo, cipo_oe, wr_strobe, frame_err;
  logic [39:0] regs_out;
  logic [6:0]  wr_addr;

  int checks = 0, failures = 0;
  int strobe_cnt = 0, err_cnt = 0, viol_cnt = 0;
  logic [6:0] strobe_addr = '0;
  logic oe_seen = 1'b0;

  spi_regfile_periph dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Counts cycles high, so a pulse longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (wr_strobe) begin strobe_cnt++; strobe_addr = wr_addr; end
    if (frame_err) err_cnt++;
    if (cipo_oe) oe_seen = 1'b1;
    if (!cipo_oe && cipo) viol_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_shift(input logic [31:0] word, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = word[i];
      #HALF;
      cap = {cap[30:0], cipo};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    copi = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] word, input int n, output logic [31:0] cap);
    ncs = 1'b0;
    #HALF;
    spi_shift(word, n, cap);
    #HALF;
    ncs = 1'b1;
    #(4*HALF);
  endtask

  logic [31:0] cap;
  int s0, e0;
  logic [7:0] exp_rd;
  logic       exp_oe;

  initial begin
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_regs", regs_out, 40'h0);
    check("rst_cipo", {cipo_oe, cipo}, 2'b00);
    check("rst_pulses", {wr_strobe, frame_err}, 2'b00);
    check("rst_wr_addr", wr_addr, 7'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // write addr 2 = A5
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(32'h82A5, 16, cap);
    check("wr2_regs", regs_out, 40'h00_00_A5_00_00);
    check("wr2_strobe", strobe_cnt - s0, 1);
    check("wr2_strobe_addr", strobe_addr, 7'h02);
    check("wr2_wr_addr", wr_addr, 7'h02);
    check("wr2_no_err", err_cnt - e0, 0);

`ifdef SPI_READ_EN
    exp_rd = 8'hA5; exp_oe = 1'b1;
`else
    exp_rd = 8'h00; exp_oe = 1'b0;
`endif

    // read addr 2
    s0 = strobe_cnt; oe_seen = 1'b0;
    spi_frame(32'h0200, 16, cap);
    check("rd2_data", cap[7:0], exp_rd);
    check("rd2_oe", oe_seen, exp_oe);
    check("rd2_oe_after", cipo_oe, 1'b0);
    check("rd2_regs", regs_out, 40'h00_00_A5_00_00);
    check("rd2_no_strobe", strobe_cnt - s0, 0);

    // write to unimplemented addr 0x10, then read it back
    s0 = strobe_cnt;
    spi_frame(32'h90FF, 16, cap);
    check("wr10_regs", regs_out, 40'h00_00_A5_00_00);
    check("wr10_no_strobe", strobe_cnt - s0, 0);
    spi_frame(32'h1000, 16, cap);
    check("rd10_data", cap[7:0], 8'h00);

    // abort after 10 bits, then a clean write of addr 1 = 5A
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(32'h8155 >> 6, 10, cap);
    check("abort_err", err_cnt - e0, 1);
    check("abort_regs", regs_out, 40'h00_00_A5_00_00);
    check("abort_no_strobe", strobe_cnt - s0, 0);
    spi_frame(32'h815A, 16, cap);
    check("wr1_regs", regs_out, 40'h00_00_A5_5A_00);
    check("wr1_strobe", strobe_cnt - s0, 1);
    check("wr1_wr_addr", wr_addr, 7'h01);

    // 24 sclk pulses in one ncs window: write addr 0 = 3C then 8 ignored bits
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(32'h803CFF, 24, cap);
    check("long_regs", regs_out, 40'h00_00_A5_5A_3C);
    check("long_strobe", strobe_cnt - s0, 1);
    check("long_no_err", err_cnt - e0, 0);

    // reset at bit 12 of a write frame with ncs held low
    ncs = 1'b0;
    #HALF;
    spi_shift(32'h8377 >> 4, 12, cap);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("midrst_regs", regs_out, 40'h0);
    check("midrst_outs", {cipo, cipo_oe, wr_strobe, frame_err}, 4'b0000);
    check("midrst_wr_addr", wr_addr, 7'h0);
    rst_n = 1'b1;
    s0 = strobe_cnt; e0 = err_cnt;
    spi_shift(32'h8377, 16, cap);
    #HALF;
    check("midrst_no_write", regs_out, 40'h0);
    check("midrst_no_strobe", strobe_cnt - s0, 0);
    ncs = 1'b1;
    #(4*HALF);
    spi_frame(32'h8377, 16, cap);
    check("rearm_regs", regs_out, 40'h00_77_00_00_00);
    check("rearm_strobe", strobe_cnt - s0, 1);
    check("rearm_wr_addr", wr_addr, 7'h03);
    check("rearm_no_err", err_cnt - e0, 0);

    check("cipo_idle_zero", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
